// File: rtl/acewrite_slave_resp.sv
// ACE write-channel subordinate: sinks one AW/W burst into word memory, returns B, waits for WACK.
// Latency: AW handshake -> wready next cycle; last W beat -> bvalid next cycle.
// Backpressure: one burst outstanding; awready held low from AW handshake until the cycle after wack.
module acewrite_slave_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W = 4,
    parameter int MEM_WORDS = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awbar,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic              wack,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_WORDS) << 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {IDLE, DATA, RESP, WACK} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ID_W-1:0]   cur_id;
    logic [7:0]        cur_len;
    logic [2:0]        cur_size;
    logic [1:0]        cur_burst;
    logic [7:0]        cnt;
    logic              err;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [ADDR_W-1:0] step, wrap_mask, next_addr, aw_size_mask;
    logic              w_hs, beat_in_range, beat_err, err_next, mem_we, aw_err, wrap_len_ok;

    always_comb begin
        step      = ADDR_W'(1) << cur_size;
        wrap_mask = ((ADDR_W'(cur_len) + ADDR_W'(1)) << cur_size) - ADDR_W'(1);
        case (cur_burst)
            BURST_FIXED: next_addr = cur_addr;
            // Low bits advance inside the aligned wrap window, high bits stay put.
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | ((cur_addr + step) & wrap_mask);
            default:     next_addr = cur_addr + step;
        endcase
    end

    assign w_hs          = wvalid & wready;
    assign beat_in_range = addr_in_range(cur_addr);
    assign beat_err      = ~beat_in_range | (wlast & (cnt < cur_len)) | (~wlast & (cnt == cur_len));
    assign err_next      = err | beat_err;
    assign mem_we        = w_hs & beat_in_range & ~err & ~rst;

    assign aw_size_mask = (ADDR_W'(1) << awsize) - ADDR_W'(1);
    assign wrap_len_ok  = (awlen == 8'd1) | (awlen == 8'd3) | (awlen == 8'd7) | (awlen == 8'd15);
    assign aw_err       = (awsize > 3'd2) | (awburst == 2'd3) |
                          ((awburst == BURST_WRAP) & (~wrap_len_ok | ((awaddr & aw_size_mask) != '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bid       <= '0;
            bresp     <= RESP_OKAY;
            err       <= 1'b0;
            cnt       <= '0;
            cur_addr  <= '0;
            cur_id    <= '0;
            cur_len   <= '0;
            cur_size  <= '0;
            cur_burst <= '0;
        end else begin
            case (state)
                IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready   <= 1'b0;
                        cur_addr  <= awaddr;
                        cur_id    <= awid;
                        cur_len   <= awlen;
                        cur_size  <= awsize;
                        cur_burst <= awburst;
                        cnt       <= '0;
                        if (awbar != 2'd0) begin
                            err    <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= awid;
                            bresp  <= RESP_OKAY;
                            state  <= RESP;
                        end else begin
                            err    <= aw_err;
                            wready <= 1'b1;
                            state  <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        cur_addr <= next_addr;
                        cnt      <= cnt + 8'd1;
                        err      <= err_next;
                        if (wlast) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= cur_id;
                            bresp  <= err_next ? RESP_SLVERR : RESP_OKAY;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= WACK;
                    end
                end
                WACK: begin
                    if (wack) begin
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Contents survive reset so a scoreboard can still inspect them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[word_index(cur_addr)][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign dbg_data = addr_in_range(dbg_addr) ? mem[word_index(dbg_addr)] : '0;
endmodule

// File: tb/tb_acewrite_slave_resp.sv
// Bench for acewrite_slave_resp: directed and random bursts checked against a byte-level memory model.
module tb_acewrite_slave_resp;
    localparam int MW = 256;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk, rst;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awbar;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready, wack;
    logic [31:0] dbg_addr, dbg_data;

    acewrite_slave_resp #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awbar(awbar),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wack(wack), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] mem_m [MW];
    logic [31:0] wd [300];
    logic [3:0]  ws [300];

    // Reference: byte-addressed memory updated beat by beat from the burst rules.
    task automatic model_apply(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [1:0] bar, input int wl,
                               output logic [1:0] exp_resp);
        bit err;
        longint stp, wb, base, ai;
        int idx;
        if (bar != 0) begin
            exp_resp = 2'd0;
            return;
        end
        stp = longint'(1) << size;
        err = (size > 2) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) ||
              (burst == 2 && (a % stp) != 0);
        wb = (longint'(len) + 1) * stp;
        for (int i = 0; i <= wl; i++) begin
            if (burst == 0) ai = a;
            else if (burst == 1) ai = a + i * stp;
            else begin
                base = a - (a % wb);
                ai = base + ((a - base + i * stp) % wb);
            end
            if (ai < BASE || ai >= BASE + 4 * MW) err = 1;
            else if (!err) begin
                idx = int'((ai - BASE) / 4);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) mem_m[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
            if (i == wl && i < len) err = 1;
            if (i != wl && i == len) err = 1;
        end
        exp_resp = err ? 2'd2 : 2'd0;
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [1:0] bar,
                             input int wl, input int bdelay, input int wdelay,
                             output logic [3:0] o_bid, output logic [1:0] o_resp,
                             output bit lat_ok, output bit hold_ok, output bit wack_ok);
        int t;
        lat_ok = 1; hold_ok = 1; wack_ok = 1; o_bid = '0; o_resp = 2'b11;
        @(posedge clk); #1;
        awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst; awbar = bar; awvalid = 1;
        t = 0;
        while (awready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            n_assert++; n_fail++;
            $display("FAIL aw_timeout awready=%b required 1", awready);
            awvalid = 0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 0;
        if (bar != 0) begin
            if (bvalid !== 1'b1 || wready !== 1'b0) lat_ok = 0;
        end else begin
            if (wready !== 1'b1) lat_ok = 0;
            for (int i = 0; i <= wl; i++) begin
                wdata = wd[i]; wstrb = ws[i]; wlast = (i == wl); wvalid = 1;
                t = 0;
                while (wready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
                if (t >= 100) begin
                    n_assert++; n_fail++;
                    $display("FAIL w_timeout beat=%0d wready=%b required 1", i, wready);
                    wvalid = 0; wlast = 0;
                    return;
                end
                @(posedge clk); #1;
            end
            wvalid = 0; wlast = 0;
            if (bvalid !== 1'b1 || wready !== 1'b0) lat_ok = 0;
        end
        t = 0;
        while (bvalid !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            n_assert++; n_fail++;
            $display("FAIL b_timeout bvalid=%b required 1", bvalid);
            return;
        end
        o_bid = bid; o_resp = bresp;
        for (int k = 0; k < bdelay; k++) begin
            @(posedge clk); #1;
            if (bvalid !== 1'b1 || bid !== o_bid || bresp !== o_resp) hold_ok = 0;
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        if (bvalid !== 1'b0) hold_ok = 0;
        for (int k = 0; k < wdelay; k++) begin
            if (awready !== 1'b0) wack_ok = 0;
            @(posedge clk); #1;
        end
        wack = 1;
        if (awready !== 1'b0) wack_ok = 0;
        @(posedge clk); #1;
        wack = 0;
        if (awready !== 1'b1) wack_ok = 0;
    endtask

    task automatic scan_mem(output int bad_idx, output logic [31:0] got, output logic [31:0] exp);
        bad_idx = -1; got = '0; exp = '0;
        for (int w = 0; w < MW; w++) begin
            dbg_addr = BASE + 32'(w * 4);
            #1;
            if (bad_idx < 0 && dbg_data !== mem_m[w]) begin
                bad_idx = w; got = dbg_data; exp = mem_m[w];
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_assert++; if (awready !== 1'b0) begin n_fail++; $display("FAIL reset_awready got=%b want=0", awready); end
        n_assert++; if (wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready got=%b want=0", wready); end
        n_assert++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid got=%b want=0", bvalid); end
        n_assert++; if (bid !== 4'd0) begin n_fail++; $display("FAIL reset_bid got=%0d want=0", bid); end
        n_assert++; if (bresp !== 2'd0) begin n_fail++; $display("FAIL reset_bresp got=%0d want=0", bresp); end
        rst = 0;
        @(posedge clk); #1;
        n_assert++; if (awready !== 1'b1) begin n_fail++; $display("FAIL reset_release_awready got=%b want=1", awready); end
    endtask

    task automatic test_fill();
        logic [1:0] er, r; logic [3:0] b; bit l, h, k; int bi; logic [31:0] g, e;
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        model_apply(BASE, 8'd255, 3'd2, 2'd1, 2'd0, 255, er);
        run_burst(BASE, 4'd3, 8'd255, 3'd2, 2'd1, 2'd0, 255, 0, 0, b, r, l, h, k);
        n_assert++; if (r !== er || b !== 4'd3) begin n_fail++; $display("FAIL fill_b got id=%0d resp=%0d want id=3 resp=%0d", b, r, er); end
        n_assert++; if (!l) begin n_fail++; $display("FAIL fill_latency got=0 want=1"); end
        scan_mem(bi, g, e);
        n_assert++; if (bi != -1) begin n_fail++; $display("FAIL fill_mem word=%0d got=%h want=%h", bi, g, e); end
    endtask

    task automatic test_incr();
        logic [1:0] er, r; logic [3:0] b; bit l, h, k;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        model_apply(32'h10, 8'd3, 3'd2, 2'd1, 2'd0, 3, er);
        run_burst(32'h10, 4'd5, 8'd3, 3'd2, 2'd1, 2'd0, 3, 0, 0, b, r, l, h, k);
        n_assert++; if (b !== 4'd5 || r !== 2'd0) begin n_fail++; $display("FAIL incr_b got id=%0d resp=%0d want id=5 resp=0", b, r); end
        n_assert++; if (!l) begin n_fail++; $display("FAIL incr_latency got=0 want=1"); end
        for (int w = 4; w < 8; w++) begin
            dbg_addr = 32'(w * 4); #1;
            n_assert++; if (dbg_data !== 32'(w - 3)) begin n_fail++; $display("FAIL incr_word%0d got=%h want=%h", w, dbg_data, w - 3); end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] er, r; logic [3:0] b; bit l, h, k;
        logic [31:0] want [4];
        want[0] = 32'hC; want[1] = 32'hD; want[2] = 32'hA; want[3] = 32'hB;
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA + 32'(i); ws[i] = 4'hF; end
        model_apply(32'h38, 8'd3, 3'd2, 2'd2, 2'd0, 3, er);
        run_burst(32'h38, 4'd1, 8'd3, 3'd2, 2'd2, 2'd0, 3, 0, 0, b, r, l, h, k);
        n_assert++; if (r !== 2'd0) begin n_fail++; $display("FAIL wrap_bresp got=%0d want=0", r); end
        for (int w = 0; w < 4; w++) begin
            dbg_addr = 32'h30 + 32'(w * 4); #1;
            n_assert++; if (dbg_data !== want[w]) begin n_fail++; $display("FAIL wrap_word%0h got=%h want=%h", 12 + w, dbg_data, want[w]); end
        end
    endtask

    task automatic test_strobe();
        logic [1:0] er, r; logic [3:0] b; bit l, h, k;
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        model_apply(32'h80, 8'd0, 3'd2, 2'd1, 2'd0, 0, er);
        run_burst(32'h80, 4'd2, 8'd0, 3'd2, 2'd1, 2'd0, 0, 0, 0, b, r, l, h, k);
        wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
        model_apply(32'h80, 8'd0, 3'd2, 2'd1, 2'd0, 0, er);
        run_burst(32'h80, 4'd2, 8'd0, 3'd2, 2'd1, 2'd0, 0, 0, 0, b, r, l, h, k);
        dbg_addr = 32'h80; #1;
        n_assert++; if (dbg_data !== 32'hFF34_FF78) begin n_fail++; $display("FAIL strobe_word got=%h want=ff34ff78", dbg_data); end
    endtask

    task automatic test_errors();
        logic [31:0] ea [8]; logic [7:0] el [8]; logic [2:0] es [8]; logic [1:0] eb [8]; int ewl [8];
        logic [1:0] er, r; logic [3:0] b; bit l, h, k; int bi; logic [31:0] g, e;
        // oor, early wlast, size3, burst3, wrap len2, wrap unaligned, overrun, run off the end
        ea = '{32'h400, 32'h100, 32'h140, 32'h180, 32'h1C0, 32'h1C2, 32'h200, 32'h3F8};
        el = '{8'd0, 8'd3, 8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd3};
        es = '{3'd2, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
        eb = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};
        ewl = '{0, 1, 1, 1, 2, 3, 3, 3};
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            model_apply(ea[c], el[c], es[c], eb[c], 2'd0, ewl[c], er);
            run_burst(ea[c], 4'(c), el[c], es[c], eb[c], 2'd0, ewl[c], 0, 0, b, r, l, h, k);
            n_assert++; if (r !== 2'd2) begin n_fail++; $display("FAIL err_bresp case=%0d got=%0d want=2", c, r); end
            n_assert++; if (!l) begin n_fail++; $display("FAIL err_latency case=%0d got=0 want=1", c); end
        end
        scan_mem(bi, g, e);
        n_assert++; if (bi != -1) begin n_fail++; $display("FAIL err_mem word=%0d got=%h want=%h", bi, g, e); end
        dbg_addr = BASE + 32'h400; #1;
        n_assert++; if (dbg_data !== 32'h0) begin n_fail++; $display("FAIL dbg_oor got=%h want=0", dbg_data); end
    endtask

    task automatic test_barrier();
        logic [1:0] r; logic [3:0] b; bit l, h, k;
        run_burst(32'h44, 4'd11, 8'd3, 3'd2, 2'd1, 2'd1, 3, 0, 0, b, r, l, h, k);
        n_assert++; if (b !== 4'd11 || r !== 2'd0) begin n_fail++; $display("FAIL barrier_b got id=%0d resp=%0d want id=11 resp=0", b, r); end
        n_assert++; if (!l) begin n_fail++; $display("FAIL barrier_latency got=0 want=1"); end
    endtask

    task automatic test_handshake();
        logic [1:0] er, r; logic [3:0] b; bit l, h, k;
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        model_apply(32'h60, 8'd1, 3'd2, 2'd1, 2'd0, 1, er);
        run_burst(32'h60, 4'd7, 8'd1, 3'd2, 2'd1, 2'd0, 1, 5, 3, b, r, l, h, k);
        n_assert++; if (!h) begin n_fail++; $display("FAIL hs_b_hold got=0 want=1"); end
        n_assert++; if (!k) begin n_fail++; $display("FAIL hs_wack_delay got=0 want=1"); end
        n_assert++; if (b !== 4'd7 || r !== er) begin n_fail++; $display("FAIL hs_b got id=%0d resp=%0d want id=7 resp=%0d", b, r, er); end
        run_burst(32'h70, 4'd8, 8'd0, 3'd2, 2'd1, 2'd1, 0, 0, 0, b, r, l, h, k);
        n_assert++; if (!k) begin n_fail++; $display("FAIL hs_wack_immediate got=0 want=1"); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] er; int t, bi; logic [31:0] g, e; bit quiet;
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        @(posedge clk); #1;
        awaddr = 32'h200; awid = 4'd9; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1; awbar = 2'd0; awvalid = 1;
        t = 0;
        while (awready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        awvalid = 0;
        for (int i = 0; i < 2; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = 0; wvalid = 1;
            t = 0;
            while (wready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
        end
        n_assert++; if (t >= 100) begin n_fail++; $display("FAIL rstmid_w_timeout wready=%b want=1", wready); end
        wvalid = 0;
        model_apply(32'h200, 8'd7, 3'd2, 2'd1, 2'd0, 1, er);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_assert++; if (wready !== 1'b0 || awready !== 1'b0) begin n_fail++; $display("FAIL rstmid_during got wready=%b awready=%b want 0 0", wready, awready); end
        @(posedge clk); #1;
        n_assert++; if (awready !== 1'b1) begin n_fail++; $display("FAIL rstmid_awready got=%b want=1", awready); end
        quiet = 1;
        for (int c = 0; c < 4; c++) begin
            if (bvalid !== 1'b0) quiet = 0;
            @(posedge clk); #1;
        end
        n_assert++; if (!quiet) begin n_fail++; $display("FAIL rstmid_no_b got bvalid=1 want=0"); end
        scan_mem(bi, g, e);
        n_assert++; if (bi != -1) begin n_fail++; $display("FAIL rstmid_mem word=%0d got=%h want=%h", bi, g, e); end
    endtask

    task automatic test_random();
        logic [7:0] wl_tab [4];
        logic [31:0] a; logic [7:0] len; logic [2:0] size; logic [1:0] burst, bar, er, r; logic [3:0] id, b;
        int wl, bi; bit l, h, k; logic [31:0] g, e;
        wl_tab = '{8'd1, 8'd3, 8'd7, 8'd15};
        for (int it = 0; it < 40; it++) begin
            burst = 2'($urandom_range(0, 2));
            size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            len = (burst == 2) ? wl_tab[$urandom_range(0, 3)] : 8'($urandom_range(0, 15));
            a = 32'($urandom_range(0, 1100));
            if ($urandom_range(0, 9) != 0) a = a & ~((32'd1 << size) - 32'd1);
            case ($urandom_range(0, 7))
                0: wl = (len > 0) ? $urandom_range(0, int'(len) - 1) : int'(len);
                1: wl = int'(len) + $urandom_range(1, 2);
                default: wl = int'(len);
            endcase
            bar = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            id = 4'($urandom);
            for (int i = 0; i <= wl; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            model_apply(a, len, size, burst, bar, wl, er);
            run_burst(a, id, len, size, burst, bar, wl, $urandom_range(0, 3), $urandom_range(0, 3), b, r, l, h, k);
            n_assert++; if (r !== er || b !== id) begin n_fail++; $display("FAIL rand_b it=%0d got id=%0d resp=%0d want id=%0d resp=%0d", it, b, r, id, er); end
            n_assert++; if (!(l && h && k)) begin n_fail++; $display("FAIL rand_handshake it=%0d got lat=%0d hold=%0d wack=%0d want 1 1 1", it, l, h, k); end
        end
        scan_mem(bi, g, e);
        n_assert++; if (bi != -1) begin n_fail++; $display("FAIL rand_mem word=%0d got=%h want=%h", bi, g, e); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awbar = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0; wack = 0; dbg_addr = '0;
        test_reset();
        test_fill();
        test_incr();
        test_wrap();
        test_strobe();
        test_errors();
        test_barrier();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
